// File: rtl/tl_pkg.sv
// Shared constants and types for the traffic-light conflict monitor.
package tl_pkg;
  localparam int NUM_APP = 4;
  localparam int LAMP_W  = 3;

  localparam int GREEN  = 2;
  localparam int YELLOW = 1;
  localparam int RED    = 0;

  localparam logic [LAMP_W-1:0] RED_ONLY = 3'b001;

  localparam logic [2:0] FC_NONE      = 3'd0;
  localparam logic [2:0] FC_BAD_CODE  = 3'd1;
  localparam logic [2:0] FC_MULTI_GO  = 3'd2;
  localparam logic [2:0] FC_PED       = 3'd3;
  localparam logic [2:0] FC_INIT_TO   = 3'd4;
  localparam logic [2:0] FC_TICK_LOSS = 3'd5;

  localparam logic [1:0] ST_INIT    = 2'd0;
  localparam logic [1:0] ST_MONITOR = 2'd1;
  localparam logic [1:0] ST_FAULT   = 2'd2;

  typedef logic [NUM_APP-1:0][LAMP_W-1:0] lamp_vec_t;

  typedef struct packed {
    lamp_vec_t          tl;
    logic [NUM_APP-1:0] ped;
  } snap_t;

  function automatic logic lamp_ok(input logic [LAMP_W-1:0] c);
    return (c == 3'b001) || (c == 3'b010) || (c == 3'b100);
  endfunction
endpackage

// File: rtl/tick_sync.sv
// Brings the controller step clock into the clk domain as a one-cycle tick.
module tick_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic secclk,
  output logic tick
);
  // [0],[1] synchronizer, [2] previous synchronized level
  logic [2:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[1:0], secclk};
  end

  assign tick = sr[1] & ~sr[2];
endmodule

// File: rtl/tl_conflict_monitor.sv
// Safety monitor between a traffic controller and the physical lamps.
module tl_conflict_monitor
  import tl_pkg::*;
#(
  parameter int unsigned CONFIRM      = 2,
  parameter int unsigned INIT_TIMEOUT = 8,
  parameter int unsigned WDOG_CYCLES  = 200_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       secclk,
  input  logic [2:0] tl_1,
  input  logic [2:0] tl_2,
  input  logic [2:0] tl_3,
  input  logic [2:0] tl_4,
  input  logic [3:0] ped_in,
  input  logic       clear_fault,
  output logic [2:0] lamp_1,
  output logic [2:0] lamp_2,
  output logic [2:0] lamp_3,
  output logic [2:0] lamp_4,
  output logic [3:0] ped_lamp,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] mon_state
);
  localparam int VW = $clog2(CONFIRM + 1);
  localparam int IW = $clog2(INIT_TIMEOUT + 1);

  logic               tick, snap_vld;
  lamp_vec_t          tl_in, lamp_q;
  logic [NUM_APP-1:0] ped_q;
  snap_t              snap;
  logic [1:0]         state;
  logic [2:0]         code_q;
  logic               flash, clear_armed;
  logic [VW-1:0]      viol_cnt, viol_nxt;
  logic [IW-1:0]      init_cnt, init_nxt;
  logic [31:0]        wdog_cnt, wdog_nxt;
  logic               viol_full, init_full, wdog_full;

  tick_sync u_sync (.clk(clk), .rst_n(rst_n), .secclk(secclk), .tick(tick));

  assign tl_in = {tl_4, tl_3, tl_2, tl_1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap     <= '0;
      snap_vld <= 1'b0;
    end else begin
      snap_vld <= tick;
      if (tick) snap <= {tl_in, ped_in};
    end
  end

  // Checks look only at the snapshot so a mid-step controller glitch is invisible.
  logic [NUM_APP-1:0] red_clear, others;
  logic [2:0]         n_clear;
  logic               bad_code, multi_go, ped_bad, all_red;
  logic [2:0]         viol_code;

  always_comb begin
    bad_code = 1'b0;
    ped_bad  = 1'b0;
    n_clear  = 3'd0;
    others   = '0;
    for (int k = 0; k < NUM_APP; k++) begin
      red_clear[k] = ~snap.tl[k][RED];
      n_clear      = n_clear + {2'b00, red_clear[k]};
      if (!lamp_ok(snap.tl[k])) bad_code = 1'b1;
    end
    // Walk lamp (k+1)%4 is served only by approach k being the sole non-red one.
    for (int k = 0; k < NUM_APP; k++) begin
      others    = red_clear;
      others[k] = 1'b0;
      if (snap.ped[(k + 1) % NUM_APP] && (snap.tl[k][RED] || (|others)))
        ped_bad = 1'b1;
    end
    multi_go  = n_clear > 3'd1;
    viol_code = bad_code ? FC_BAD_CODE :
                multi_go ? FC_MULTI_GO :
                ped_bad  ? FC_PED      : FC_NONE;
    all_red   = (snap.tl == {NUM_APP{RED_ONLY}}) && (snap.ped == '0);
  end

  assign viol_nxt  = viol_cnt + VW'(1);
  assign init_nxt  = init_cnt + IW'(1);
  assign wdog_nxt  = wdog_cnt + 32'd1;
  assign viol_full = viol_nxt == VW'(CONFIRM);
  assign init_full = init_nxt == IW'(INIT_TIMEOUT);
  assign wdog_full = wdog_nxt == WDOG_CYCLES;

  logic       fault_req;
  logic [2:0] req_code;

  always_comb begin
    fault_req = 1'b0;
    req_code  = FC_NONE;
    if (state == ST_INIT) begin
      if (snap_vld && !all_red && init_full) begin
        fault_req = 1'b1;
        req_code  = FC_INIT_TO;
      end else if (!tick && wdog_full) begin
        fault_req = 1'b1;
        req_code  = FC_TICK_LOSS;
      end
    end else if (state == ST_MONITOR) begin
      if (snap_vld && (viol_code != FC_NONE) && viol_full) begin
        fault_req = 1'b1;
        req_code  = viol_code;
      end else if (!tick && wdog_full) begin
        fault_req = 1'b1;
        req_code  = FC_TICK_LOSS;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_INIT;
      lamp_q      <= {NUM_APP{RED_ONLY}};
      ped_q       <= '0;
      code_q      <= FC_NONE;
      flash       <= 1'b0;
      clear_armed <= 1'b0;
      viol_cnt    <= '0;
      init_cnt    <= '0;
      wdog_cnt    <= '0;
    end else if (fault_req) begin
      state       <= ST_FAULT;
      code_q      <= req_code;
      lamp_q      <= {NUM_APP{RED_ONLY}};
      ped_q       <= '0;
      flash       <= 1'b1;
      clear_armed <= 1'b0;
      viol_cnt    <= '0;
      init_cnt    <= '0;
      wdog_cnt    <= '0;
    end else begin
      if (state != ST_FAULT) wdog_cnt <= tick ? 32'd0 : wdog_nxt;
      case (state)
        ST_INIT: if (snap_vld) begin
          if (all_red) begin
            state    <= ST_MONITOR;
            init_cnt <= '0;
            viol_cnt <= '0;
          end else begin
            init_cnt <= init_nxt;
          end
        end
        // An unconfirmed violation holds the last clean lamp image.
        ST_MONITOR: if (snap_vld) begin
          if (viol_code != FC_NONE) begin
            viol_cnt <= viol_nxt;
          end else begin
            viol_cnt <= '0;
            lamp_q   <= snap.tl;
            ped_q    <= snap.ped;
          end
        end
        ST_FAULT: begin
          if (clear_fault) clear_armed <= 1'b1;
          if (snap_vld) begin
            if (clear_armed && all_red) begin
              state       <= ST_INIT;
              code_q      <= FC_NONE;
              clear_armed <= 1'b0;
              flash       <= 1'b0;
              wdog_cnt    <= '0;
            end else begin
              flash <= ~flash;
            end
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  assign {lamp_4, lamp_3, lamp_2, lamp_1} =
    (state == ST_FAULT) ? {NUM_APP{{2'b00, flash}}} : lamp_q;
  assign ped_lamp   = (state == ST_FAULT) ? 4'b0000 : ped_q;
  assign fault      = state == ST_FAULT;
  assign fault_code = code_q;
  assign mon_state  = state;
endmodule

// File: tb/tb_tl_conflict_monitor.sv
// Directed bench for tl_conflict_monitor (CONFIRM=2, INIT_TIMEOUT=8, WDOG_CYCLES=50).
module tb_tl_conflict_monitor;
  logic       clk = 1'b0;
  logic       rst_n, secclk, clear_fault;
  logic [2:0] tl_1, tl_2, tl_3, tl_4;
  logic [3:0] ped_in;
  logic [2:0] lamp_1, lamp_2, lamp_3, lamp_4;
  logic [3:0] ped_lamp;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] mon_state;
  logic [11:0] lamps_all;

  int total = 0;
  int bad   = 0;

  tl_conflict_monitor #(.CONFIRM(2), .INIT_TIMEOUT(8), .WDOG_CYCLES(50)) dut (
    .clk(clk), .rst_n(rst_n), .secclk(secclk),
    .tl_1(tl_1), .tl_2(tl_2), .tl_3(tl_3), .tl_4(tl_4),
    .ped_in(ped_in), .clear_fault(clear_fault),
    .lamp_1(lamp_1), .lamp_2(lamp_2), .lamp_3(lamp_3), .lamp_4(lamp_4),
    .ped_lamp(ped_lamp), .fault(fault), .fault_code(fault_code),
    .mon_state(mon_state)
  );

  always #5 clk = ~clk;
  assign lamps_all = {lamp_4, lamp_3, lamp_2, lamp_1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    secclk = 1'b1;
    step(4);
    secclk = 1'b0;
    step(4);
  endtask

  task automatic set_in(input logic [2:0] a, b, c, d, input logic [3:0] p);
    tl_1 = a; tl_2 = b; tl_3 = c; tl_4 = d; ped_in = p;
  endtask

  task automatic pulse_clear();
    clear_fault = 1'b1;
    step(1);
    clear_fault = 1'b0;
  endtask

  // Clear an active fault and walk back through INIT into MONITOR.
  task automatic recover(input string tag);
    pulse_clear();
    set_in(3'b001, 3'b001, 3'b001, 3'b001, 4'b0000);
    do_tick();
    check({tag, "_init"}, 32'(mon_state), 32'd0);
    check({tag, "_code0"}, 32'(fault_code), 32'd0);
    do_tick();
    check({tag, "_mon"}, 32'(mon_state), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; secclk = 1'b0; clear_fault = 1'b0;
    set_in(3'b001, 3'b001, 3'b001, 3'b001, 4'b0000);
    step(3);
    check("rst_state", 32'(mon_state), 32'd0);
    check("rst_lamps", 32'(lamps_all), 32'h249);
    check("rst_ped",   32'(ped_lamp), 32'h0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_code",  32'(fault_code), 32'd0);
    rst_n = 1'b1;
    step(1);

    do_tick();
    check("init_to_mon", 32'(mon_state), 32'd1);

    // Lamp update lands two clocks after the tick pulse.
    set_in(3'b100, 3'b001, 3'b001, 3'b001, 4'b0010);
    secclk = 1'b1;
    step(3);
    check("pass_early", 32'(lamp_1), 32'b001);
    step(1);
    check("pass_lamp1", 32'(lamp_1), 32'b100);
    check("pass_ped",   32'(ped_lamp), 32'b0010);
    secclk = 1'b0;
    step(4);

    // Single bad code then clean: no fault.
    set_in(3'b001, 3'b110, 3'b001, 3'b001, 4'b0000);
    do_tick();
    check("bad1_nofault", 32'(fault), 32'd0);
    set_in(3'b001, 3'b001, 3'b001, 3'b001, 4'b0000);
    do_tick();
    check("clean_nofault", 32'(fault), 32'd0);
    set_in(3'b001, 3'b110, 3'b001, 3'b001, 4'b0000);
    do_tick();
    check("bad_a_nofault", 32'(fault), 32'd0);
    do_tick();
    check("bad_fault", 32'(fault), 32'd1);
    check("bad_code",  32'(fault_code), 32'd1);
    check("bad_lamps", 32'(lamps_all), 32'h249);
    recover("rec1");

    // Two greens.
    set_in(3'b100, 3'b001, 3'b100, 3'b001, 4'b0000);
    do_tick();
    check("mg_first", 32'(fault), 32'd0);
    do_tick();
    check("mg_fault", 32'(fault), 32'd1);
    check("mg_code",  32'(fault_code), 32'd2);
    check("mg_flash1", 32'(lamps_all), 32'h249);
    check("mg_ped",   32'(ped_lamp), 32'h0);
    do_tick();
    check("mg_flash0", 32'(lamps_all), 32'h000);
    do_tick();
    check("mg_flash1b", 32'(lamps_all), 32'h249);
    pulse_clear();
    do_tick();
    check("armed_notred", 32'(mon_state), 32'd2);
    check("armed_flash0", 32'(lamps_all), 32'h000);
    set_in(3'b001, 3'b001, 3'b001, 3'b001, 4'b0000);
    do_tick();
    check("armed_exit", 32'(mon_state), 32'd0);
    check("armed_code0", 32'(fault_code), 32'd0);
    check("armed_lamps", 32'(lamps_all), 32'h249);
    do_tick();
    check("armed_mon", 32'(mon_state), 32'd1);

    // Walk conflict, then bad code taking priority over walk conflict.
    set_in(3'b100, 3'b001, 3'b001, 3'b001, 4'b0100);
    do_tick();
    check("ped_first", 32'(fault), 32'd0);
    do_tick();
    check("ped_code", 32'(fault_code), 32'd3);
    recover("rec2");
    set_in(3'b100, 3'b011, 3'b001, 3'b001, 4'b0100);
    do_tick();
    do_tick();
    check("prio_code", 32'(fault_code), 32'd1);
    recover("rec3");

    // clear_fault outside FAULT must not pre-arm a later clear.
    pulse_clear();
    set_in(3'b001, 3'b110, 3'b001, 3'b001, 4'b0000);
    do_tick();
    do_tick();
    check("ign_fault", 32'(fault_code), 32'd1);
    set_in(3'b001, 3'b001, 3'b001, 3'b001, 4'b0000);
    do_tick();
    check("ign_stay", 32'(mon_state), 32'd2);
    recover("rec4");

    // Watchdog: counter is 5 on return from do_tick, fault at the 50th count.
    step(44);
    check("wdog_before", 32'(fault), 32'd0);
    step(1);
    check("wdog_fault", 32'(fault), 32'd1);
    check("wdog_code",  32'(fault_code), 32'd5);
    pulse_clear();
    do_tick();
    check("wdog_clr_state", 32'(mon_state), 32'd0);
    check("wdog_clr_code",  32'(fault_code), 32'd0);

    // INIT timeout after a fresh reset.
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    set_in(3'b000, 3'b000, 3'b000, 3'b000, 4'b0000);
    repeat (7) do_tick();
    check("ito_before", 32'(fault), 32'd0);
    do_tick();
    check("ito_fault", 32'(fault), 32'd1);
    check("ito_code",  32'(fault_code), 32'd4);
    do_tick();
    check("ito_flash0", 32'(lamps_all), 32'h000);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state", 32'(mon_state), 32'd0);
    check("arst_lamps", 32'(lamps_all), 32'h249);
    check("arst_code",  32'(fault_code), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
